// File: rtl/game_flow_if.sv
// game_flow_if: bundle between the game-flow controller and its neighbours.
// The master side (movement/collision logic, player switch) drives start,
// tick and the per-enemy pulses. The slave side (game_flow_ctrl) drives the
// game status and the VGA background colour.
interface game_flow_if #(
  parameter int N_ENEMIES = 3,
  parameter int HEALTH_W  = 3,
  parameter int SCORE_W   = 16
);
  logic                 start;
  logic                 tick;
  logic [N_ENEMIES-1:0] enemy_reach;
  logic [N_ENEMIES-1:0] enemy_kill;
  logic [1:0]           state;
  logic                 playing;
  logic                 game_end;
  logic [HEALTH_W-1:0]  health;
  logic [SCORE_W-1:0]   score;
  logic                 health_update;
  logic [SCORE_W-1:0]   high_score;
  logic [7:0]           bg_color;

  modport master (
    output start, tick, enemy_reach, enemy_kill,
    input  state, playing, game_end, health, score, health_update,
           high_score, bg_color
  );

  modport slave (
    input  start, tick, enemy_reach, enemy_kill,
    output state, playing, game_end, health, score, health_update,
           high_score, bg_color
  );
endinterface

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: top-level game FSM (HOME/PLAY/HIT/END) with multi-point
// health, saturating score, post-hit invulnerability and background colour.
// Optional feature macro: GAME_FLOW_HIGH_SCORE_EN keeps a best-score register
// and tints the HOME screen when a best score exists. When undefined,
// high_score is tied to zero and HOME is always white.
module game_flow_ctrl #(
  parameter int N_ENEMIES    = 3,
  parameter int HEALTH_W     = 3,
  parameter int MAX_HEALTH   = 5,
  parameter int SCORE_W      = 16,
  parameter int INVULN_TICKS = 30
) (
  input  logic          clk,
  input  logic          rst,
  game_flow_if.slave    bus
);

  localparam int CNT_W = $clog2(N_ENEMIES + 1);
  // Wide enough that both health and the damage count fit with a sign bit.
  localparam int SUB_W = ((CNT_W > HEALTH_W) ? CNT_W : HEALTH_W) + 1;

  localparam logic [7:0] BG_HOME = 8'hFF;
  localparam logic [7:0] BG_PLAY = 8'h00;
  localparam logic [7:0] BG_HIT  = 8'hE0;
  localparam logic [7:0] BG_END  = 8'h03;

  typedef enum logic [1:0] {
    S_HOME = 2'd0,
    S_PLAY = 2'd1,
    S_HIT  = 2'd2,
    S_END  = 2'd3
  } state_t;

  state_t              state_reg;
  logic [HEALTH_W-1:0] health_reg;
  logic [SCORE_W-1:0]  score_reg;
  logic                health_update_reg;
  logic                playing_reg;
  logic                game_end_reg;
  logic [7:0]          bg_color_reg;
  logic [7:0]          inv_cnt_reg;
  // Holds "start was low last cycle". Clearing it on reset means a start
  // level held through reset is not mistaken for a fresh press.
  logic                start_low_reg;

  logic [CNT_W-1:0]    dmg;
  logic [CNT_W-1:0]    kills;
  logic [SUB_W-1:0]    health_diff;
  logic [HEALTH_W-1:0] health_dec;
  logic [SCORE_W:0]    score_sum;
  logic [SCORE_W-1:0]  score_next;
  logic                start_rise;
  logic                end_entry;
  logic [7:0]          home_bg;

  // Population counts of the reach and kill pulse vectors.
  always_comb begin
    dmg   = '0;
    kills = '0;
    for (int i = 0; i < N_ENEMIES; i++) begin
      dmg   = dmg   + CNT_W'(bus.enemy_reach[i]);
      kills = kills + CNT_W'(bus.enemy_kill[i]);
    end
  end

  // Health after damage clamps at zero; the extra top bit flags underflow.
  assign health_diff = SUB_W'(health_reg) - SUB_W'(dmg);
  assign health_dec  = health_diff[SUB_W-1] ? '0 : health_diff[HEALTH_W-1:0];

  // Score after kills saturates at all-ones.
  assign score_sum  = {1'b0, score_reg} + (SCORE_W+1)'(kills);
  assign score_next = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];

  assign start_rise = bus.start & start_low_reg;
  // The only way into END: a damaging hit in PLAY that empties health.
  assign end_entry  = (state_reg == S_PLAY) && bus.start && (dmg != '0) &&
                      (health_dec == '0);

`ifdef GAME_FLOW_HIGH_SCORE_EN
  logic [SCORE_W-1:0] high_score_reg;

  // Best score is captured on each entry to END; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      high_score_reg <= '0;
    end else if (end_entry && (score_next > high_score_reg)) begin
      high_score_reg <= score_next;
    end
  end

  assign home_bg        = (high_score_reg != '0) ? 8'hFC : BG_HOME;
  assign bus.high_score = high_score_reg;
`else
  assign home_bg        = BG_HOME;
  assign bus.high_score = '0;
`endif

  // Game FSM with all status outputs registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg         <= S_HOME;
      health_reg        <= '0;
      score_reg         <= '0;
      health_update_reg <= 1'b0;
      playing_reg       <= 1'b0;
      game_end_reg      <= 1'b0;
      bg_color_reg      <= BG_HOME;
      inv_cnt_reg       <= '0;
      start_low_reg     <= 1'b0;
    end else begin
      start_low_reg     <= ~bus.start;
      health_update_reg <= 1'b0;
      case (state_reg)
        S_HOME: begin
          if (start_rise) begin
            state_reg    <= S_PLAY;
            health_reg   <= HEALTH_W'(MAX_HEALTH);
            score_reg    <= '0;
            inv_cnt_reg  <= '0;
            playing_reg  <= 1'b1;
            bg_color_reg <= BG_PLAY;
          end
        end
        S_PLAY: begin
          if (!bus.start) begin
            // Abort wins over any damage this cycle; score and health hold.
            state_reg    <= S_HOME;
            playing_reg  <= 1'b0;
            bg_color_reg <= home_bg;
          end else begin
            score_reg <= score_next;
            if (dmg != '0) begin
              health_reg        <= health_dec;
              health_update_reg <= 1'b1;
              if (end_entry) begin
                state_reg    <= S_END;
                playing_reg  <= 1'b0;
                game_end_reg <= 1'b1;
                bg_color_reg <= BG_END;
              end else begin
                state_reg    <= S_HIT;
                inv_cnt_reg  <= 8'(INVULN_TICKS);
                bg_color_reg <= BG_HIT;
              end
            end
          end
        end
        S_HIT: begin
          if (!bus.start) begin
            state_reg    <= S_HOME;
            playing_reg  <= 1'b0;
            bg_color_reg <= home_bg;
          end else begin
            score_reg <= score_next;
            if (bus.tick) begin
              if (inv_cnt_reg <= 8'd1) begin
                inv_cnt_reg  <= '0;
                state_reg    <= S_PLAY;
                bg_color_reg <= BG_PLAY;
              end else begin
                inv_cnt_reg <= inv_cnt_reg - 8'd1;
              end
            end
          end
        end
        S_END: begin
          if (!bus.start) begin
            state_reg    <= S_HOME;
            game_end_reg <= 1'b0;
            bg_color_reg <= home_bg;
          end
        end
        default: begin
          state_reg <= S_HOME;
        end
      endcase
    end
  end

  assign bus.state         = state_reg;
  assign bus.playing       = playing_reg;
  assign bus.game_end      = game_end_reg;
  assign bus.health        = health_reg;
  assign bus.score         = score_reg;
  assign bus.health_update = health_update_reg;
  assign bus.bg_color      = bg_color_reg;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: scoreboard bench for game_flow_ctrl. The driver applies
// one input set per clock, advances a behavioural game model and queues the
// expected outputs; the monitor pops one entry per clock and compares.
// Score width is reduced to 4 bits so saturation is reached quickly.
module tb_game_flow_ctrl;

  localparam int N_EN   = 3;
  localparam int HW     = 3;
  localparam int MAXH   = 5;
  localparam int SW     = 4;
  localparam int INV    = 30;
  localparam int SMAX   = (1 << SW) - 1;

  localparam int M_HOME = 0;
  localparam int M_PLAY = 1;
  localparam int M_HIT  = 2;
  localparam int M_END  = 3;

  typedef struct {
    int st;
    int h;
    int sc;
    int upd;
    int pl;
    int ge;
    int bg;
    int hs;
  } exp_t;

  logic clk;
  logic rst;

  game_flow_if #(.N_ENEMIES(N_EN), .HEALTH_W(HW), .SCORE_W(SW)) bus ();

  game_flow_ctrl #(
    .N_ENEMIES(N_EN), .HEALTH_W(HW), .MAX_HEALTH(MAXH),
    .SCORE_W(SW), .INVULN_TICKS(INV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int txn    = 0;
  exp_t exp_q[$];

  // Behavioural model of the game.
  int  m_st      = M_HOME;
  int  m_h       = 0;
  int  m_sc      = 0;
  int  m_cnt     = 0;
  int  m_hs      = 0;
  bit  m_prev_lo = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (txn %0d)", name, act, req, txn);
    end
  endtask

  function automatic int color_of(input int st, input int hs);
    case (st)
      M_PLAY:  return 'h00;
      M_HIT:   return 'hE0;
      M_END:   return 'h03;
      default: begin
`ifdef GAME_FLOW_HIGH_SCORE_EN
        return (hs != 0) ? 'hFC : 'hFF;
`else
        return 'hFF;
`endif
      end
    endcase
  endfunction

  // Apply one cycle of inputs, advance the model, queue the expected result.
  task automatic cycle(input bit s, input bit t,
                       input logic [N_EN-1:0] r, input logic [N_EN-1:0] k);
    int   dmg;
    int   kl;
    int   upd;
    exp_t e;
    bus.start       = s;
    bus.tick        = t;
    bus.enemy_reach = r;
    bus.enemy_kill  = k;
    dmg = $countones(r);
    kl  = $countones(k);
    upd = 0;
    if (m_st == M_HOME) begin
      if (s && m_prev_lo) begin
        m_st = M_PLAY; m_h = MAXH; m_sc = 0; m_cnt = 0;
      end
    end else if (m_st == M_END) begin
      if (!s) m_st = M_HOME;
    end else if (!s) begin
      m_st = M_HOME;
    end else begin
      m_sc = (m_sc + kl > SMAX) ? SMAX : m_sc + kl;
      if (m_st == M_PLAY) begin
        if (dmg > 0) begin
          upd = 1;
          m_h = (m_h - dmg < 0) ? 0 : m_h - dmg;
          if (m_h == 0) begin
            m_st = M_END;
`ifdef GAME_FLOW_HIGH_SCORE_EN
            if (m_sc > m_hs) m_hs = m_sc;
`endif
          end else begin
            m_st = M_HIT; m_cnt = INV;
          end
        end
      end else if (t) begin
        m_cnt = m_cnt - 1;
        if (m_cnt <= 0) begin
          m_cnt = 0; m_st = M_PLAY;
        end
      end
    end
    m_prev_lo = !s;
    e.st  = m_st;
    e.h   = m_h;
    e.sc  = m_sc;
    e.upd = upd;
    e.pl  = (m_st == M_PLAY || m_st == M_HIT) ? 1 : 0;
    e.ge  = (m_st == M_END) ? 1 : 0;
    e.bg  = color_of(m_st, m_hs);
    e.hs  = m_hs;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, '0, '0);
  endtask

  // Each tick is followed by a quiet cycle so the return to PLAY is visible.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(1'b1, 1'b1, '0, '0);
      cycle(1'b1, 1'b0, '0, '0);
    end
  endtask

  task automatic new_game();
    cycle(1'b0, 1'b0, '0, '0);
    cycle(1'b1, 1'b0, '0, '0);
  endtask

  // Monitor: one registered output set per clock, compared against the queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        txn++;
        $display("TXN %0d state=%0d health=%0d score=%0d upd=%0b bg=%02h hs=%0d",
                 txn, bus.state, bus.health, bus.score, bus.health_update,
                 bus.bg_color, bus.high_score);
        chk("state",         int'(bus.state),         e.st);
        chk("health",        int'(bus.health),        e.h);
        chk("score",         int'(bus.score),         e.sc);
        chk("health_update", int'(bus.health_update), e.upd);
        chk("playing",       int'(bus.playing),       e.pl);
        chk("game_end",      int'(bus.game_end),      e.ge);
        chk("bg_color",      int'(bus.bg_color),      e.bg);
        chk("high_score",    int'(bus.high_score),    e.hs);
      end
    end
  end

  // Driver: directed scenarios, then randomized play.
  initial begin
    rst             = 1'b1;
    bus.start       = 1'b1;
    bus.tick        = 1'b0;
    bus.enemy_reach = '0;
    bus.enemy_kill  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state",    int'(bus.state),         0);
    chk("rst_health",   int'(bus.health),        0);
    chk("rst_score",    int'(bus.score),         0);
    chk("rst_upd",      int'(bus.health_update), 0);
    chk("rst_playing",  int'(bus.playing),       0);
    chk("rst_game_end", int'(bus.game_end),      0);
    chk("rst_bg",       int'(bus.bg_color),      'hFF);
    chk("rst_hs",       int'(bus.high_score),    0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Start held through reset must not begin a game.
    idle(4);
    new_game();
    idle(2);

    // Two-point hit, kill and ignored reach during HIT, then invulnerability.
    cycle(1'b1, 1'b0, 3'b101, '0);
    idle(1);
    cycle(1'b1, 1'b0, 3'b111, 3'b111);
    cycle(1'b1, 1'b0, 3'b010, '0);
    ticks(INV);
    idle(2);

    // Whittle health to 1, then an over-kill hit clamps at 0 and ends.
    cycle(1'b1, 1'b0, 3'b001, '0);
    ticks(INV);
    cycle(1'b1, 1'b0, 3'b100, '0);
    ticks(INV);
    cycle(1'b1, 1'b0, 3'b111, 3'b001);
    idle(3);
    cycle(1'b0, 1'b0, '0, '0);
    idle(2);

    // Score saturation: 12, 14, then 14+2 clamps to 15.
    new_game();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, '0, 3'b111);
    cycle(1'b1, 1'b0, '0, 3'b011);
    cycle(1'b1, 1'b0, '0, 3'b011);
    cycle(1'b1, 1'b0, '0, 3'b111);

    // Abort together with a reach pulse: back to HOME, nothing else moves.
    cycle(1'b0, 1'b0, 3'b111, 3'b001);
    idle(2);

    // Game 1 to score 7, game 2 to score 4; both end.
    new_game();
    cycle(1'b1, 1'b0, '0, 3'b111);
    cycle(1'b1, 1'b0, '0, 3'b111);
    cycle(1'b1, 1'b0, '0, 3'b001);
    cycle(1'b1, 1'b0, 3'b111, '0);
    ticks(INV);
    cycle(1'b1, 1'b0, 3'b111, '0);
    cycle(1'b0, 1'b0, '0, '0);
    idle(2);
    cycle(1'b1, 1'b0, '0, '0);
    cycle(1'b1, 1'b0, '0, 3'b110);
    cycle(1'b1, 1'b0, '0, 3'b011);
    cycle(1'b1, 1'b0, 3'b111, '0);
    ticks(INV);
    cycle(1'b1, 1'b0, 3'b111, '0);
    cycle(1'b0, 1'b0, '0, '0);
    idle(2);

    // Randomized play.
    for (int i = 0; i < 2500; i++) begin
      bit s;
      bit t;
      logic [N_EN-1:0] r;
      logic [N_EN-1:0] k;
      s = ($urandom_range(0, 79) != 0);
      t = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 11) == 0) ? N_EN'($urandom_range(0, 7)) : '0;
      k = ($urandom_range(0, 3) == 0) ? N_EN'($urandom_range(0, 7)) : '0;
      cycle(s, t, r, k);
    end

    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
